poolb_dp_nunit: RTL

Parametrised 2x2 stride-2 pooling datapath that replaces the fixed three-unit pooling datapath with `NUM_UNITS` channel lanes, a selectable max/average mode and a valid/ready handshake. Each accepted beat carries one column of two adjacent feature-map rows (row A, row B) for every lane. The block pairs consecutive columns, emits one pooled value per lane per column pair, and tracks frame position so downstream logic sees an end-of-frame marker. It sits between the convolution output buffers and the next layer's input FIFO.

---
 rtl/poolb_dp_nunit_if.sv | 35 +++
 rtl/poolb_dp_nunit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/poolb_dp_nunit_if.sv
// -----------------------------------------------------------------------------
// poolb_dp_nunit_if
// Stream bundle for the 2x2 stride-2 pooling datapath.
//   Input side : in_valid / in_ready handshake, data_in_A (row A column sample
//                per lane), data_in_B (row B column sample per lane).
//   Output side: out_valid / out_ready handshake, data_out (pooled value per
//                lane), out_last (final result of a frame).
//   Lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH] of every packed vector.
// Modports:
//   master - the surrounding logic (drives beats, accepts results)
//   slave  - the pooling block itself
// -----------------------------------------------------------------------------
interface poolb_dp_nunit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_UNITS  = 3
);
   logic                            in_valid;
   logic                            in_ready;
   logic [NUM_UNITS*DATA_WIDTH-1:0] data_in_A;
   logic [NUM_UNITS*DATA_WIDTH-1:0] data_in_B;
   logic                            out_valid;
   logic                            out_ready;
   logic [NUM_UNITS*DATA_WIDTH-1:0] data_out;
   logic                            out_last;

   modport master (
      output in_valid, data_in_A, data_in_B, out_ready,
      input  in_ready, out_valid, data_out, out_last
   );

   modport slave (
      input  in_valid, data_in_A, data_in_B, out_ready,
      output in_ready, out_valid, data_out, out_last
   );
endinterface

// File: rtl/poolb_dp_nunit.sv
// -----------------------------------------------------------------------------
// poolb_dp_nunit
// 2x2 stride-2 pooling over NUM_UNITS parallel channel lanes. Each accepted
// beat is one column of two adjacent rows (A, B). Even columns are reduced into
// a per-lane partial; the following odd column completes the 2x2 window and
// loads the output register. With an odd IFM_SIZE the last column of each row
// pair is accepted and dropped.
//
// Parameters:
//   DATA_WIDTH - signed sample width
//   IFM_SIZE   - feature-map width/height (>= 2)
//   NUM_UNITS  - number of lanes (>= 1)
//   POOL_MODE  - 0 = max, 1 = average (floor of sum/4)
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - poolb_dp_nunit_if.slave (input beats in, pooled results out)
// Build option:
//   POOLB_RELU_EN - when defined, negative results are clamped to zero before
//                   they are loaded into the output register.
// -----------------------------------------------------------------------------
module poolb_dp_nunit #(
   parameter int DATA_WIDTH = 32,
   parameter int IFM_SIZE   = 10,
   parameter int NUM_UNITS  = 3,
   parameter int POOL_MODE  = 0
) (
   input logic              clk,
   input logic              reset,
   poolb_dp_nunit_if.slave  bus
);

   localparam int PW    = DATA_WIDTH + 1;   // partial sum A+B
   localparam int SW    = DATA_WIDTH + 2;   // full 4-sample sum
   localparam int COL_W = $clog2(IFM_SIZE);
   localparam int RP_N  = IFM_SIZE / 2;
   localparam int RP_W  = (RP_N > 1) ? $clog2(RP_N) : 1;
   localparam bit ODD_SIZE = (IFM_SIZE % 2) == 1;

   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IFM_SIZE - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(2 * RP_N - 1);
   localparam logic [RP_W-1:0]  RP_MAX   = RP_W'(RP_N - 1);

   typedef enum logic {ST_FIRST, ST_SECOND} state_t;

   function automatic logic signed [DATA_WIDTH-1:0] smax(
      input logic signed [DATA_WIDTH-1:0] x,
      input logic signed [DATA_WIDTH-1:0] y
   );
      return (x > y) ? x : y;
   endfunction

   // Reduction of one column (rows A and B) into the partial register.
   function automatic logic signed [PW-1:0] pair_value(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      logic signed [DATA_WIDTH-1:0] m;
      if (POOL_MODE == 1) begin
         return {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      end
      m = smax(a, b);
      return {m[DATA_WIDTH-1], m};
   endfunction

`ifdef POOLB_RELU_EN
   function automatic logic signed [DATA_WIDTH-1:0] relu(
      input logic signed [DATA_WIDTH-1:0] v
   );
      return (v < 0) ? '0 : v;
   endfunction
`endif

   // Completes the 2x2 window. The average path keeps two guard bits so the
   // arithmetic shift always lands back inside DATA_WIDTH.
   function automatic logic signed [DATA_WIDTH-1:0] final_value(
      input logic signed [PW-1:0]         p,
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      logic signed [SW-1:0]         sum;
      logic signed [SW-1:0]         shr;
      logic signed [DATA_WIDTH-1:0] res;
      if (POOL_MODE == 1) begin
         sum = {p[PW-1], p} + {{2{a[DATA_WIDTH-1]}}, a} + {{2{b[DATA_WIDTH-1]}}, b};
         shr = sum >>> 2;
         res = shr[DATA_WIDTH-1:0];
      end else begin
         res = smax($signed(p[DATA_WIDTH-1:0]), smax(a, b));
      end
`ifdef POOLB_RELU_EN
      res = relu(res);
`endif
      return res;
   endfunction

   state_t                       state;
   state_t                       state_nxt;
   logic [COL_W-1:0]             col;
   logic [RP_W-1:0]              rp;
   logic                         accept;
   logic                         drop_col;
   logic                         load_part;
   logic                         load_out;
   logic                         is_last;

   logic signed [DATA_WIDTH-1:0] a_s       [NUM_UNITS];
   logic signed [DATA_WIDTH-1:0] b_s       [NUM_UNITS];
   logic signed [PW-1:0]         pair_s    [NUM_UNITS];
   logic signed [DATA_WIDTH-1:0] fin_s     [NUM_UNITS];

   logic signed [PW-1:0]         partial_p0 [NUM_UNITS];
   logic signed [DATA_WIDTH-1:0] result_p1  [NUM_UNITS];
   logic                         vld_p1;
   logic                         last_p1;
   logic [NUM_UNITS*DATA_WIDTH-1:0] data_out_w;

   // Stall only while a result is held and downstream refuses it.
   assign bus.in_ready = !(vld_p1 && !bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign drop_col     = ODD_SIZE && (col == COL_MAX);
   assign is_last      = (col == LAST_COL) && (rp == RP_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_FIRST;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FIRST:  if (accept && !drop_col) state_nxt = ST_SECOND;
         ST_SECOND: if (accept)              state_nxt = ST_FIRST;
         default:                            state_nxt = ST_FIRST;
      endcase
   end

   always_comb begin
      load_part = 1'b0;
      load_out  = 1'b0;
      if (accept) begin
         if (state == ST_SECOND) begin
            load_out = 1'b1;
         end else if (!drop_col) begin
            load_part = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col <= '0;
         rp  <= '0;
      end else if (accept) begin
         if (col == COL_MAX) begin
            col <= '0;
            rp  <= (rp == RP_MAX) ? '0 : rp + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Stage 0: per-lane column reduction and window completion
   always_comb begin
      for (int k = 0; k < NUM_UNITS; k++) begin
         a_s[k]    = $signed(bus.data_in_A[k*DATA_WIDTH +: DATA_WIDTH]);
         b_s[k]    = $signed(bus.data_in_B[k*DATA_WIDTH +: DATA_WIDTH]);
         pair_s[k] = pair_value(a_s[k], b_s[k]);
         fin_s[k]  = final_value(partial_p0[k], a_s[k], b_s[k]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_UNITS; k++) begin
            partial_p0[k] <= '0;
         end
      end else if (load_part) begin
         for (int k = 0; k < NUM_UNITS; k++) begin
            partial_p0[k] <= pair_s[k];
         end
      end
   end

   // Stage 1: output register, held while downstream stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         for (int k = 0; k < NUM_UNITS; k++) begin
            result_p1[k] <= '0;
         end
      end else begin
         if (load_out) begin
            vld_p1  <= 1'b1;
            last_p1 <= is_last;
            for (int k = 0; k < NUM_UNITS; k++) begin
               result_p1[k] <= fin_s[k];
            end
         end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   always_comb begin
      data_out_w = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         data_out_w[k*DATA_WIDTH +: DATA_WIDTH] = result_p1[k];
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_last  = last_p1;
   assign bus.data_out  = data_out_w;

endmodule
